// File: rtl/cv32e40x_lsu_txn_tracker.sv
// LSU-side transaction tracker in front of cv32e40x_wpt: counts outstanding transfers and pairs responses with requests.
// Optional sticky first-watchpoint-match capture is enabled by defining CV32E40X_TRACKER_WPT_STICKY_EN.

package cv32e40x_lsu_txn_tracker_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_data_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] wpt_match;
    } data_resp_t;
endpackage

module cv32e40x_lsu_txn_tracker
    import cv32e40x_lsu_txn_tracker_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lsu_trans_valid_i,
    output logic             lsu_trans_ready_o,
    input  logic             lsu_trans_pushpop_i,
    input  obi_data_req_t    lsu_trans_i,
    output logic             wpt_trans_valid_o,
    input  logic             wpt_trans_ready_i,
    output logic             wpt_trans_pushpop_o,
    output obi_data_req_t    wpt_trans_o,
    input  logic             wpt_resp_valid_i,
    input  data_resp_t       wpt_resp_i,
    output logic             lsu_resp_valid_o,
    output data_resp_t       lsu_resp_o,
    output logic             lsu_resp_we_o,
    output logic             one_txn_pend_n_o,
    output logic             wpt_wait_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             unexp_resp_o,
    output logic [31:0]      wpt_first_match_o,
    input  logic             wpt_match_clr_i
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] fill_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic             we_mem_q [DEPTH];
    logic             not_full;
    logic             acc;
    logic             rsp;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A slot freed by a same-cycle response only becomes usable next cycle.
    assign not_full          = (cnt_q < CNT_W'(DEPTH));
    assign wpt_trans_valid_o = lsu_trans_valid_i && not_full;
    assign lsu_trans_ready_o = wpt_trans_ready_i && not_full;
    assign acc               = wpt_trans_valid_o && wpt_trans_ready_i;
    assign rsp               = wpt_resp_valid_i && (cnt_q != '0);

    assign wpt_trans_pushpop_o = lsu_trans_pushpop_i;
    assign wpt_trans_o         = lsu_trans_i;
    assign wpt_wait_o          = 1'b1;

    assign cnt_n            = cnt_q + CNT_W'(acc) - CNT_W'(rsp);
    assign cnt_o            = cnt_q;
    assign one_txn_pend_n_o = (cnt_n == CNT_W'(1));

    // Responses are never stalled; unexpected ones are dropped and flagged.
    assign lsu_resp_valid_o = rsp;
    assign lsu_resp_o       = wpt_resp_i;
    assign unexp_resp_o     = wpt_resp_valid_i && (cnt_q == '0);
    assign lsu_resp_we_o    = (fill_q != '0) && we_mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                we_mem_q[i] <= 1'b0;
            end
        end else begin
            fill_q <= fill_q + CNT_W'(acc) - CNT_W'(rsp);
            if (acc) begin
                we_mem_q[wr_ptr_q] <= lsu_trans_i.we;
                wr_ptr_q           <= ptr_inc(wr_ptr_q);
            end
            if (rsp) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

`ifdef CV32E40X_TRACKER_WPT_STICKY_EN
    logic [31:0] first_match_q;

    // Clear wins over a capture in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_match_q <= '0;
        end else if (wpt_match_clr_i) begin
            first_match_q <= '0;
        end else if (rsp && (wpt_resp_i.wpt_match != '0) && (first_match_q == '0)) begin
            first_match_q <= wpt_resp_i.wpt_match;
        end
    end

    assign wpt_first_match_o = first_match_q;
`else
    logic unused_match_clr;

    assign unused_match_clr  = wpt_match_clr_i;
    assign wpt_first_match_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40x_lsu_txn_tracker.sv
// Bench for cv32e40x_lsu_txn_tracker: directed scenarios plus random traffic against a queue-based reference model.
// Build with CV32E40X_TRACKER_WPT_STICKY_EN defined to cover the sticky match capture.

module tb_cv32e40x_lsu_txn_tracker;
    import cv32e40x_lsu_txn_tracker_pkg::*;

    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             lsu_trans_valid_i = 1'b0;
    logic             lsu_trans_ready_o;
    logic             lsu_trans_pushpop_i = 1'b0;
    obi_data_req_t    lsu_trans_i = '0;
    logic             wpt_trans_valid_o;
    logic             wpt_trans_ready_i = 1'b0;
    logic             wpt_trans_pushpop_o;
    obi_data_req_t    wpt_trans_o;
    logic             wpt_resp_valid_i = 1'b0;
    data_resp_t       wpt_resp_i = '0;
    logic             lsu_resp_valid_o;
    data_resp_t       lsu_resp_o;
    logic             lsu_resp_we_o;
    logic             one_txn_pend_n_o;
    logic             wpt_wait_o;
    logic [CNT_W-1:0] cnt_o;
    logic             unexp_resp_o;
    logic [31:0]      wpt_first_match_o;
    logic             wpt_match_clr_i = 1'b0;

    cv32e40x_lsu_txn_tracker #(.DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .lsu_trans_valid_i   (lsu_trans_valid_i),
        .lsu_trans_ready_o   (lsu_trans_ready_o),
        .lsu_trans_pushpop_i (lsu_trans_pushpop_i),
        .lsu_trans_i         (lsu_trans_i),
        .wpt_trans_valid_o   (wpt_trans_valid_o),
        .wpt_trans_ready_i   (wpt_trans_ready_i),
        .wpt_trans_pushpop_o (wpt_trans_pushpop_o),
        .wpt_trans_o         (wpt_trans_o),
        .wpt_resp_valid_i    (wpt_resp_valid_i),
        .wpt_resp_i          (wpt_resp_i),
        .lsu_resp_valid_o    (lsu_resp_valid_o),
        .lsu_resp_o          (lsu_resp_o),
        .lsu_resp_we_o       (lsu_resp_we_o),
        .one_txn_pend_n_o    (one_txn_pend_n_o),
        .wpt_wait_o          (wpt_wait_o),
        .cnt_o               (cnt_o),
        .unexp_resp_o        (unexp_resp_o),
        .wpt_first_match_o   (wpt_first_match_o),
        .wpt_match_clr_i     (wpt_match_clr_i)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Scoreboard state: expected {we, rdata} per delivered response, plus the reference model
    logic [32:0] exp_q[$];
    logic        model_q[$];
    logic [31:0] sticky_m = '0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive inputs after the edge, predict and check combinational outputs, advance the model.
    task automatic cycle(input logic v, input logic r, input logic we,
                         input logic rv, input logic [31:0] match, input logic clr);
        int   n;
        logic acc_e;
        logic rsp_e;
        int   n_next;
        @(posedge clk);
        #1;
        lsu_trans_valid_i     = v;
        wpt_trans_ready_i     = r;
        lsu_trans_pushpop_i   = 1'($urandom_range(0, 1));
        lsu_trans_i.addr      = $urandom;
        lsu_trans_i.we        = we;
        lsu_trans_i.be        = 4'($urandom_range(0, 15));
        lsu_trans_i.wdata     = $urandom;
        wpt_resp_valid_i      = rv;
        wpt_resp_i.rdata      = $urandom;
        wpt_resp_i.err        = 1'($urandom_range(0, 1));
        wpt_resp_i.wpt_match  = match;
        wpt_match_clr_i       = clr;
        #2;
        n      = model_q.size();
        acc_e  = v && r && (n < DEPTH);
        rsp_e  = rv && (n != 0);
        n_next = n + int'(acc_e) - int'(rsp_e);
        check("cnt_o", 96'(cnt_o), 96'(n));
        check("lsu_trans_ready_o", 96'(lsu_trans_ready_o), 96'(r && (n < DEPTH)));
        check("wpt_trans_valid_o", 96'(wpt_trans_valid_o), 96'(v && (n < DEPTH)));
        check("one_txn_pend_n_o", 96'(one_txn_pend_n_o), 96'(n_next == 1));
        check("unexp_resp_o", 96'(unexp_resp_o), 96'(rv && (n == 0)));
        check("lsu_resp_valid_o", 96'(lsu_resp_valid_o), 96'(rsp_e));
        check("wpt_trans_o", 96'(wpt_trans_o), 96'(lsu_trans_i));
        check("wpt_trans_pushpop_o", 96'(wpt_trans_pushpop_o), 96'(lsu_trans_pushpop_i));
        check("wpt_wait_o", 96'(wpt_wait_o), 96'(1));
        check("wpt_first_match_o", 96'(wpt_first_match_o), 96'(sticky_m));
        if (rsp_e) begin
            exp_q.push_back({model_q[0], wpt_resp_i.rdata});
            void'(model_q.pop_front());
        end
        if (acc_e) model_q.push_back(we);
`ifdef CV32E40X_TRACKER_WPT_STICKY_EN
        if (clr) sticky_m = '0;
        else if (rsp_e && (match != '0) && (sticky_m == '0)) sticky_m = match;
`endif
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        lsu_trans_valid_i = 1'b0;
        wpt_trans_ready_i = 1'b0;
        wpt_resp_valid_i  = 1'b0;
        wpt_match_clr_i   = 1'b0;
        rst_n             = 1'b0;
        #2;
        model_q.delete();
        sticky_m = '0;
        check("reset cnt_o", 96'(cnt_o), 96'(0));
        check("reset one_txn_pend_n_o", 96'(one_txn_pend_n_o), 96'(0));
        check("reset lsu_resp_we_o", 96'(lsu_resp_we_o), 96'(0));
        check("reset wpt_wait_o", 96'(wpt_wait_o), 96'(1));
        check("reset unexp_resp_o", 96'(unexp_resp_o), 96'(0));
        check("reset wpt_first_match_o", 96'(wpt_first_match_o), 96'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: pops the expected queue whenever the DUT delivers a response
    always @(negedge clk) begin
        logic [32:0] e;
        if (lsu_resp_valid_o) begin
            if (exp_q.size() == 0) begin
                check("resp without expectation", 96'(lsu_resp_valid_o), 96'(0));
            end else begin
                e = exp_q.pop_front();
                check("resp we/rdata", 96'({lsu_resp_we_o, lsu_resp_o.rdata}), 96'(e));
            end
        end
        check("cnt_o within depth", 96'(cnt_o <= CNT_W'(DEPTH)), 96'(1));
        check("fifo fill equals cnt_o", 96'(dut.fill_q), 96'(cnt_o));
    end

    initial begin
        do_reset();

        // Three back-to-back requests: only two fit
        cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        // Full: response plus request in the same cycle does not bypass
        cycle(1'b1, 1'b1, 1'b1, 1'b1, '0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        // Drain the two outstanding responses
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);

        // we ordering: we=1 then we=0, two responses
        cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);

        // Single request from empty, then its response
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        idle();

        // Unexpected response with nothing outstanding
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        idle();

        // Sticky capture: matches 0x2 then 0x1, then clear
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h2, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h1, 1'b0);
        idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        idle();

        // Reset with transactions in flight; later responses are unexpected
        cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        idle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 15)) : 32'h0,
                  1'($urandom_range(0, 15) == 0));
        end

        // Drain whatever is still outstanding, bounded by the depth
        for (int i = 0; i < DEPTH + 2; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        end
        idle();
        @(posedge clk);
        #1;
        check("expected queue drained", 96'(exp_q.size()), 96'(0));
        check("model drained", 96'(model_q.size()), 96'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
